// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter and two-phase (psel/penable) transfer sequencer
// sharing one register/memory slave among NREQ requesters.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/write/addr/wdata   per-requester request (addr/wdata flattened)
//   req_ready                    combinational one-hot accept
//   rsp_valid, rsp_rdata         one-cycle completion pulse, shared read data
//   busy                         transfer in progress
//   psel/penable/pwrite/paddr/pwdata, prdata   slave side
//
// Optional: define WB_RR_ARBITER_LOCK_EN to add req_lock, which pins grants
// to the locking requester until it issues an unlocked request.
module wb_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
`ifdef WB_RR_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AW-1:0]     paddr,
  output logic [DW-1:0]     pwdata,
  input  logic [DW-1:0]     prdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;
  logic          found;
  logic [NREQ-1:0] elig;
  int            idx;

  logic [AW-1:0] addr_a  [NREQ];
  logic [DW-1:0] wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*AW +: AW];
    assign wdata_a[g] = req_wdata[g*DW +: DW];
  end

`ifdef WB_RR_ARBITER_LOCK_EN
  logic          lock_on;
  logic [IW-1:0] lock_id;

  // While locked only the lock owner is eligible, even when it is idle.
  always_comb begin
    elig = req_valid;
    if (lock_on) begin
      elig = '0;
      elig[lock_id] = req_valid[lock_id];
    end
  end
`else
  assign elig = req_valid;
`endif

  // First eligible requester after the last winner, in wrap-around order.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    if (state == IDLE || state == RESP) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(last) + k) % NREQ;
        if (!found && elig[IW'(idx)]) begin
          found = 1'b1;
          win   = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found) req_ready[win] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      last      <= IW'(NREQ - 1);
      owner     <= '0;
`ifdef WB_RR_ARBITER_LOCK_EN
      lock_on   <= 1'b0;
      lock_id   <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: ;
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= RESP;
        end
        RESP: begin
          rsp_valid[owner] <= 1'b1;
          rsp_rdata        <= pwrite ? '0 : prdata;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A grant (only possible in IDLE/RESP) overrides the next state.
      if (found) begin
        state   <= SETUP;
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= req_write[win];
        paddr   <= addr_a[win];
        pwdata  <= wdata_a[win];
        owner   <= win;
        last    <= win;
`ifdef WB_RR_ARBITER_LOCK_EN
        lock_on <= req_lock[win];
        lock_id <= win;
`endif
      end
    end
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter and transfer sequencer that shares the single-port Wishbone register/memory slave (psel/penable two-phase protocol, 8-bit word address, 32-bit data) among NREQ requesters.
- Accepts one request at a time, drives the SETUP → ENABLE sequence to the slave, captures read data and returns a per-requester response pulse.
- Sits between the CPU-side bridges/DMA ports and the slave's dutintf signals.

Parameters:
- NREQ, 4, number of requesters (1..8).
- AW, 8, slave word-address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  flattened; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened; requester i at [i*DW +: DW].
- req_ready  out  NREQ  combinational accept, one-hot or zero.
- rsp_valid  out  NREQ  one-cycle completion pulse, one-hot or zero.
- rsp_rdata  out  DW  read data, shared, valid with rsp_valid.
- busy  out  1  transfer in progress (state != IDLE).
- psel  out  1  to slave.
- penable  out  1  to slave.
- pwrite  out  1  to slave.
- paddr  out  AW  to slave.
- pwdata  out  DW  to slave.
- prdata  in  DW  from slave.

Behaviour:
- Reset values (while rst = 1 at a clk edge):
  - state = IDLE.
  - psel, penable, pwrite = 0; paddr, pwdata = 0.
  - rsp_valid = 0; rsp_rdata = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has top priority first.
- Reset mid-transfer: abandons the transfer, no rsp_valid is issued, and psel/penable drop in the next cycle.
- States: IDLE, SETUP, ACCESS, RESP.
- Grant:
  - Evaluated combinationally in IDLE and RESP only.
  - Winner = first i with req_valid[i] = 1, searching last+1, last+2, … modulo NREQ.
  - req_ready[winner] = 1; all other bits 0; all bits 0 in SETUP and ACCESS.
- Accept (valid & ready at an edge):
  - Registers paddr, pwdata, pwrite and the owner id.
  - Sets last = winner, psel = 1, penable = 0, state → SETUP.
- SETUP: next edge sets penable = 1, state → ACCESS.
- ACCESS (psel = penable = 1): next edge clears psel and penable, state → RESP. The slave writes or loads prdata at this edge.
- RESP:
  - At the edge leaving RESP: rsp_valid[owner] = 1 for exactly one cycle.
  - rsp_rdata = prdata for reads, 0 for writes.
  - If a grant exists in RESP, that request is accepted at the same edge (state → SETUP); otherwise state → IDLE.
- Timing:
  - Accept in cycle T → psel in T+1, penable in T+2, rsp_valid in T+4.
  - Back-to-back sustained rate: one transfer per 3 cycles.
- psel is never asserted in the cycle immediately after ACCESS. This guarantees the slave returns to its SETUP state before the next transfer.
- rsp_rdata holds its value until the next rsp_valid.
- Requester rules:
  - A requester may drop req_valid before ready; this is not an error and nothing is issued.
  - After acceptance, req_* inputs are don't-care.
- Simultaneous requests from all requesters are served in pointer order; the pointer wraps from NREQ-1 to 0.
- NREQ = 1: the pointer is constant and req_ready = req_valid in IDLE/RESP.

Optional Feature:
- Macro WB_RR_ARBITER_LOCK_EN.
- When defined:
  - Adds port req_lock in NREQ.
  - An accepted request with req_lock[i] = 1 sets lock_owner = i. Until owner i is accepted with req_lock = 0, grants go only to i; other requesters see req_ready = 0 even when i is idle.
  - Reset clears the lock.
- When undefined: no port, plain round-robin.

Test Plan:
- Single write then read: requester 0 writes 0xDEADBEEF to addr 0x10 (accepted T=0), then reads 0x10.
  - psel rises T+1, penable rises T+2.
  - Write rsp_valid[0] at T+4 with rsp_rdata = 0.
  - Read rsp_valid[0] with rsp_rdata = 0xDEADBEEF.
- Fairness: req_valid = 4'b1111 held continuously, distinct addresses → grant order 0,1,2,3,0,… with a rsp_valid every 3 cycles and no psel in any post-ACCESS cycle.
- Pointer wrap: after a grant to requester 3, requesters 0 and 2 request simultaneously → requester 0 granted first.
- Withdraw: requester 1 raises req_valid in SETUP and drops it before RESP → no grant, no bus activity, state returns to IDLE.
- Reset mid-ACCESS: rst during ACCESS → next cycle psel = penable = 0, no rsp_valid; a following read of the same address completes normally.
- LOCK (with macro): requester 2 issues a locked write, requester 0 is pending → requester 2's next two reads are granted before requester 0, and requester 0 is served after requester 2's unlocked request.
